// File: rtl/rx_checksum_ext.sv
// rx_checksum_ext
//
// Receive checksum offload. Snoops the post-MAC receive AXI stream and, for
// every frame, computes the 16-bit folded ones-complement sum (not inverted)
// of all bytes at or beyond a runtime start offset. The offset is latched on
// each frame's first beat. Each result carries the number of bytes summed.
// Results queue in a small show-ahead FIFO with ready/valid handshake. A
// result that arrives while the FIFO is full, with no pop in the same cycle,
// is dropped and flagged.
//
// Pipeline: mask + stage-0 word-pair sums (1 reg), LEVELS-2 adder-tree
// stages, accumulate/fold (1 reg), FIFO write (1 reg). A tlast beat on cycle
// T is visible at the FIFO head on cycle T+LEVELS+1 when the FIFO was empty.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_axis_tdata/tkeep  beat data and byte enables (lane j = bits 8j+7:8j)
//   s_axis_tvalid/tlast beat valid (always consumed) and end of frame
//   cfg_start_offset    first byte to sum, sampled on each frame's first beat
//   m_axis_csum         folded ones-complement sum at the FIFO head
//   m_axis_csum_len     bytes covered by that sum (saturating)
//   m_axis_csum_valid   FIFO head valid
//   m_axis_csum_ready   consumer accepts the head
//   stat_csum_drop      one-cycle pulse when a result is discarded

module rx_checksum_ext #(
  parameter int DATA_WIDTH   = 256,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int OFFSET_WIDTH = 8,
  parameter int LEN_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic [OFFSET_WIDTH-1:0] cfg_start_offset,
  output logic [15:0]             m_axis_csum,
  output logic [LEN_WIDTH-1:0]    m_axis_csum_len,
  output logic                    m_axis_csum_valid,
  input  logic                    m_axis_csum_ready,
  output logic                    stat_csum_drop
);

  localparam int LEVELS = $clog2(KEEP_WIDTH);
  localparam int NG     = KEEP_WIDTH / 4;        // stage-0 sums
  localparam int NN     = 2 * NG - 1;            // nodes across all tree levels
  localparam int TW     = 15 + LEVELS;           // width that holds the root sum
  localparam int CW     = LEVELS + 1;            // holds a count up to KEEP_WIDTH
  localparam int PW     = OFFSET_WIDTH + LEVELS + 1;
  localparam int FAW    = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // Frame tracking and byte mask
  // ---------------------------------------------------------------------
  logic                    in_frame_reg;
  logic [OFFSET_WIDTH-1:0] start_reg;
  logic [PW-1:0]           base_reg;   // byte position of lane 0 in this beat

  logic                    first_beat;
  logic [OFFSET_WIDTH-1:0] start_eff;
  logic [PW-1:0]           base_eff;
  logic                    base_sat;

  assign first_beat = ~in_frame_reg;
  assign start_eff  = first_beat ? cfg_start_offset : start_reg;
  assign base_eff   = first_beat ? '0 : base_reg;
  // Once the beat base passes every possible offset all bytes are included,
  // so the base stops counting instead of wrapping on long frames.
  assign base_sat   = |base_eff[PW-1:OFFSET_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame_reg <= 1'b0;
      start_reg    <= '0;
      base_reg     <= '0;
    end else if (s_axis_tvalid) begin
      start_reg <= start_eff;
      if (s_axis_tlast) begin
        in_frame_reg <= 1'b0;
        base_reg     <= '0;
      end else begin
        in_frame_reg <= 1'b1;
        base_reg     <= base_sat ? base_eff : base_eff + PW'(KEEP_WIDTH);
      end
    end
  end

  logic [KEEP_WIDTH-1:0] incl;
  logic [7:0]            byte_m [KEEP_WIDTH];
  logic [16:0]           g_sum  [NG];
  logic [2:0]            g_cnt  [NG];

  genvar gi;
  generate
    for (gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
      assign incl[gi]   = s_axis_tkeep[gi] &&
                          ((base_eff + PW'(gi)) >= PW'(start_eff));
      assign byte_m[gi] = incl[gi] ? s_axis_tdata[8*gi +: 8] : 8'h00;
    end

    // Even lane is the MSB of a big-endian word; each group of four lanes
    // yields two words that are summed into one 17-bit stage-0 value.
    for (gi = 0; gi < NG; gi++) begin : g_grp
      assign g_sum[gi] = {1'b0, byte_m[4*gi],   byte_m[4*gi+1]} +
                         {1'b0, byte_m[4*gi+2], byte_m[4*gi+3]};
      assign g_cnt[gi] = 3'(incl[4*gi])   + 3'(incl[4*gi+1]) +
                         3'(incl[4*gi+2]) + 3'(incl[4*gi+3]);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Adder and length trees. Nodes 0..NG-1 are stage 0; node i >= NG sums
  // nodes 2i-2NG and 2i-2NG+1, so each level sits one register after the
  // previous one and the root is node NN-1.
  // ---------------------------------------------------------------------
  logic [TW-1:0] node_sum_reg [NN];
  logic [CW-1:0] node_cnt_reg [NN];

  generate
    for (gi = 0; gi < NG; gi++) begin : g_stage0
      always_ff @(posedge clk) begin
        node_sum_reg[gi] <= TW'(g_sum[gi]);
        node_cnt_reg[gi] <= CW'(g_cnt[gi]);
      end
    end

    for (gi = NG; gi < NN; gi++) begin : g_tree
      always_ff @(posedge clk) begin
        node_sum_reg[gi] <= node_sum_reg[2*gi-2*NG] + node_sum_reg[2*gi-2*NG+1];
        node_cnt_reg[gi] <= node_cnt_reg[2*gi-2*NG] + node_cnt_reg[2*gi-2*NG+1];
      end
    end
  endgenerate

  logic [LEVELS-2:0] pipe_vld_reg;
  logic [LEVELS-2:0] pipe_last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_reg  <= '0;
      pipe_last_reg <= '0;
    end else begin
      pipe_vld_reg  <= (pipe_vld_reg << 1)  | (LEVELS-1)'(s_axis_tvalid);
      pipe_last_reg <= (pipe_last_reg << 1) | (LEVELS-1)'(s_axis_tlast);
    end
  end

  logic          root_vld;
  logic          root_last;
  logic [TW-1:0] root_sum;
  logic [CW-1:0] root_cnt;

  assign root_vld  = pipe_vld_reg[LEVELS-2];
  assign root_last = pipe_last_reg[LEVELS-2];
  assign root_sum  = node_sum_reg[NN-1];
  assign root_cnt  = node_cnt_reg[NN-1];

  // ---------------------------------------------------------------------
  // Accumulate and fold
  // ---------------------------------------------------------------------
  logic [15:0]          acc_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic                 res_vld_reg;
  logic [15:0]          res_csum_reg;
  logic [LEN_WIDTH-1:0] res_len_reg;

  logic [TW:0]          acc_sum;
  logic [17:0]          fold1;
  logic [15:0]          fold2;
  logic [LEN_WIDTH:0]   len_sum;
  logic [LEN_WIDTH-1:0] len_sat;

  // Two end-around-carry folds are enough: after the first the value is at
  // most 0xFFFF plus a small carry, and the second cannot carry out again.
  assign acc_sum = (TW+1)'(acc_reg) + (TW+1)'(root_sum);
  assign fold1   = 18'(acc_sum[15:0]) + 18'(acc_sum[TW:16]);
  assign fold2   = fold1[15:0] + 16'(fold1[17:16]);
  assign len_sum = (LEN_WIDTH+1)'(len_reg) + (LEN_WIDTH+1)'(root_cnt);
  assign len_sat = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg      <= '0;
      len_reg      <= '0;
      res_vld_reg  <= 1'b0;
      res_csum_reg <= '0;
      res_len_reg  <= '0;
    end else begin
      res_vld_reg <= root_vld && root_last;
      if (root_vld) begin
        if (root_last) begin
          res_csum_reg <= fold2;
          res_len_reg  <= len_sat;
          acc_reg      <= '0;
          len_reg      <= '0;
        end else begin
          acc_reg <= fold2;
          len_reg <= len_sat;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Result FIFO (show-ahead; outputs read as zero while empty)
  // ---------------------------------------------------------------------
  logic [15:0]          fifo_csum_mem [FIFO_DEPTH];
  logic [LEN_WIDTH-1:0] fifo_len_mem  [FIFO_DEPTH];
  logic [FAW-1:0]       wr_ptr_reg;
  logic [FAW-1:0]       rd_ptr_reg;
  logic [FAW:0]         count_reg;

  logic fifo_empty;
  logic fifo_full;
  logic fifo_pop;
  logic fifo_wr;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (FAW+1)'(FIFO_DEPTH));
  assign fifo_pop   = ~fifo_empty && m_axis_csum_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign fifo_wr    = res_vld_reg && (~fifo_full || fifo_pop);

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_csum_mem[wr_ptr_reg] <= res_csum_reg;
      fifo_len_mem[wr_ptr_reg]  <= res_len_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_wr)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fifo_wr, fifo_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign m_axis_csum_valid = ~fifo_empty;
  assign m_axis_csum       = fifo_empty ? 16'h0000 : fifo_csum_mem[rd_ptr_reg];
  assign m_axis_csum_len   = fifo_empty ? '0 : fifo_len_mem[rd_ptr_reg];
  assign stat_csum_drop    = res_vld_reg && fifo_full && ~fifo_pop;

endmodule

// File: tb/tb_rx_checksum_ext.sv
// tb_rx_checksum_ext
//
// Directed bench for rx_checksum_ext at DATA_WIDTH=64. Frames are built in
// a byte buffer and driven beat by beat; the expected {csum, len} of every
// frame that should reach the consumer is queued when it is driven and
// compared when the FIFO head is accepted.

module tb_rx_checksum_ext;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int OW = 8;
  localparam int LW = 16;
  localparam int FD = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic [OW-1:0] cfg_start_offset;
  logic [15:0]   m_axis_csum;
  logic [LW-1:0] m_axis_csum_len;
  logic          m_axis_csum_valid;
  logic          m_axis_csum_ready;
  logic          stat_csum_drop;

  rx_checksum_ext #(
    .DATA_WIDTH  (DW),
    .KEEP_WIDTH  (KW),
    .OFFSET_WIDTH(OW),
    .LEN_WIDTH   (LW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .cfg_start_offset (cfg_start_offset),
    .m_axis_csum      (m_axis_csum),
    .m_axis_csum_len  (m_axis_csum_len),
    .m_axis_csum_valid(m_axis_csum_valid),
    .m_axis_csum_ready(m_axis_csum_ready),
    .stat_csum_drop   (stat_csum_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors    = 0;
  int          miscompares = 0;
  int          drop_cnt   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  fb [64];
  bit          fk [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain byte-serial ones-complement sum over included bytes.
  function automatic logic [31:0] model(input int nbeats, input int s);
    int unsigned sum = 0;
    int          len = 0;
    logic [7:0]  hi, lo;
    for (int p = 0; p < nbeats * KW; p += 2) begin
      hi = (fk[p]   && p     >= s) ? fb[p]   : 8'h00;
      lo = (fk[p+1] && p + 1 >= s) ? fb[p+1] : 8'h00;
      len += (fk[p]   && p     >= s) ? 1 : 0;
      len += (fk[p+1] && p + 1 >= s) ? 1 : 0;
      sum += {16'h0000, hi, lo};
    end
    while ((sum >> 16) != 0) sum = (sum & 32'h0000_ffff) + (sum >> 16);
    return {sum[15:0], len[15:0]};
  endfunction

  task automatic set_bytes(input int lo, input int hi, input logic [7:0] v, input bit k);
    for (int i = lo; i <= hi; i++) begin
      fb[i] = v;
      fk[i] = k;
    end
  endtask

  task automatic rand_bytes(input int n, input bit rand_keep);
    for (int i = 0; i < n; i++) begin
      fb[i] = 8'($urandom);
      fk[i] = rand_keep ? ($urandom_range(0, 9) != 0) : 1'b1;
    end
  endtask

  // Offset s is presented on the first beat; mid_cfg on the rest.
  task automatic send_frame(input int nbeats, input int s, input int mid_cfg,
                            input bit push, input bit with_last);
    if (push) exp_q.push_back(model(nbeats, s));
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      for (int j = 0; j < KW; j++) begin
        s_axis_tdata[8*j +: 8] = fb[b*KW + j];
        s_axis_tkeep[j]        = fk[b*KW + j];
      end
      s_axis_tlast     = with_last && (b == nbeats - 1);
      cfg_start_offset = OW'((b == 0) ? s : mid_cfg);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = '0;
    s_axis_tdata  = '0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Consumer side: every accepted head is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (stat_csum_drop) drop_cnt++;
      if (m_axis_csum_valid && m_axis_csum_ready) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_result: observed %h expected none",
                 {m_axis_csum, m_axis_csum_len});
        end
        if (exp_q.size() != 0) chk("result", {m_axis_csum, m_axis_csum_len}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    cfg_start_offset = '0;
    m_axis_csum_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_csum",  32'(m_axis_csum), 32'd0);
    chk("reset_len",   32'(m_axis_csum_len), 32'd0);
    chk("reset_valid", 32'(m_axis_csum_valid), 32'd0);
    chk("reset_drop",  32'(stat_csum_drop), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Offset 14, 24-byte frame, bytes 14..23 = 0x01; latency check.
    set_bytes(0, 23, 8'h00, 1'b1);
    set_bytes(14, 23, 8'h01, 1'b1);
    send_frame(3, 14, 14, 1'b0, 1'b1);
    exp_q.push_back({16'h0505, 16'd10});
    idle();
    repeat (2) @(negedge clk);
    chk("latency_early", 32'(m_axis_csum_valid), 32'd0);
    @(negedge clk);
    chk("latency_valid", 32'(m_axis_csum_valid), 32'd1);
    drain("drain_offset14");

    // Single beat, partial keep: AB CD EF.
    set_bytes(0, 7, 8'h00, 1'b0);
    fb[0] = 8'hAB; fb[1] = 8'hCD; fb[2] = 8'hEF;
    fk[0] = 1'b1;  fk[1] = 1'b1;  fk[2] = 1'b1;
    send_frame(1, 0, 0, 1'b0, 1'b1);
    exp_q.push_back({16'h9ACE, 16'd3});

    // Carry fold: all 0xFF then all 0x00, back to back.
    set_bytes(0, 15, 8'hFF, 1'b1);
    send_frame(2, 0, 0, 1'b0, 1'b1);
    exp_q.push_back({16'hFFFF, 16'd16});
    set_bytes(0, 15, 8'h00, 1'b1);
    send_frame(2, 0, 0, 1'b0, 1'b1);
    exp_q.push_back({16'h0000, 16'd16});
    idle();
    drain("drain_fold");

    // Offset latching: mid-frame cfg changes are ignored.
    rand_bytes(16, 1'b0);
    send_frame(2, 0, 20, 1'b1, 1'b1);
    rand_bytes(32, 1'b0);
    send_frame(4, 20, 0, 1'b1, 1'b1);
    rand_bytes(16, 1'b0);
    send_frame(2, 40, 0, 1'b0, 1'b1);
    exp_q.push_back({16'h0000, 16'd0});
    idle();
    drain("drain_latch");

    // Random back-to-back frames with random offsets and keeps.
    for (int f = 0; f < 8; f++) begin
      int nb;
      nb = $urandom_range(1, 4);
      rand_bytes(nb * KW, 1'b1);
      send_frame(nb, $urandom_range(0, 35), $urandom_range(0, 255), 1'b1, 1'b1);
    end
    idle();
    drain("drain_random");

    // Backpressure: five frames into a four-entry FIFO.
    @(posedge clk); #1;
    m_axis_csum_ready = 1'b0;
    drop_cnt = 0;
    for (int f = 0; f < 5; f++) begin
      rand_bytes(16, 1'b0);
      send_frame(2, f, 0, (f < 4), 1'b1);
    end
    idle();
    repeat (8) @(negedge clk);
    chk("bp_drop_count", 32'(drop_cnt), 32'd1);
    chk("bp_valid_held", 32'(m_axis_csum_valid), 32'd1);
    @(posedge clk); #1;
    m_axis_csum_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_drain_valid", 32'(m_axis_csum_valid), 32'd1);
    end
    @(negedge clk);
    chk("bp_drain_empty", 32'(m_axis_csum_valid), 32'd0);
    chk("bp_scoreboard", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with a result already waiting in the FIFO.
    @(posedge clk); #1;
    m_axis_csum_ready = 1'b0;
    rand_bytes(8, 1'b0);
    send_frame(1, 0, 0, 1'b0, 1'b1);
    idle();
    repeat (6) @(negedge clk);
    chk("pre_reset_valid", 32'(m_axis_csum_valid), 32'd1);
    rand_bytes(24, 1'b0);
    send_frame(2, 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_valid", 32'(m_axis_csum_valid), 32'd0);
    chk("post_reset_head", {m_axis_csum, m_axis_csum_len}, 32'd0);
    @(posedge clk); #1;
    m_axis_csum_ready = 1'b1;
    rand_bytes(16, 1'b0);
    send_frame(2, 4, 0, 1'b1, 1'b1);
    idle();
    drain("drain_after_reset");
    repeat (8) @(negedge clk);
    chk("final_empty", 32'(m_axis_csum_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
